wb_buffer: RTL

- Writeback buffer between the execute/writeback path and the single-ported register file.
- Register file accepts a write only when neither operand read is active, so results from execute are queued here.
- Queued results drain into the register file on cycles with no operand read.
- Forwarded operand values are supplied for any register whose write is still queued, so decode never reads stale data.

---
 rtl/wb_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_buffer.sv
// wb_buffer: writeback queue between execute and the single-ported register file.
// Results are queued in a circular FIFO and drained into the register file on
// cycles with no operand read. Decode gets forwarded values for any register
// whose write is still queued.
// Optional build macro: WB_COALESCE_EN (merge a push into the youngest entry
// when both target the same register).
module wb_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    input  logic          read_rs1,
    input  logic          read_rs2,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    output logic          rf_rd_write,
    output logic [31:0]   rf_rd,
    output logic [31:0]   rf_rd_data,
    output logic          fwd_rs1_hit,
    output logic [31:0]   fwd_rs1,
    output logic          fwd_rs2_hit,
    output logic [31:0]   fwd_rs2,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]       mem_rd   [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             empty_q;
    logic             push;
    logic             pop;
    logic             alloc;
    logic             coal;

    // The register file port is free only when decode is not reading it.
    assign pop         = !empty_q && !read_rs1 && !read_rs2;
    assign rf_rd_write = pop;

`ifdef WB_COALESCE_EN
    logic [AW-1:0] tail_m1;
    logic          youngest_match;

    assign tail_m1        = tail - AW'(1);
    assign youngest_match = !empty_q && (mem_rd[tail_m1] == wb_rd);
    assign wb_ready       = (count_q < CW'(DEPTH)) || youngest_match;
    // A youngest entry that is also leaving this edge cannot absorb the push.
    assign coal           = push && youngest_match && !(pop && count_q == CW'(1));
`else
    assign wb_ready = count_q < CW'(DEPTH);
    assign coal     = 1'b0;
`endif

    // x0 writes complete the handshake but are never stored.
    assign push  = wb_valid && wb_ready && (wb_rd != 5'd0);
    assign alloc = push && !coal;

    // Occupancy after this edge.
    always_comb begin
        count_next = count_q + CW'(alloc) - CW'(pop);
    end

    // Pointers, valid bits and registered occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ent_vld <= '0;
        end else begin
            if (pop) begin
                head          <= head + AW'(1);
                ent_vld[head] <= 1'b0;
            end
            if (alloc) begin
                tail          <= tail + AW'(1);
                ent_vld[tail] <= 1'b1;
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
        end
    end

    // Entry payload storage; contents are qualified by ent_vld so no reset needed.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_rd[tail]   <= wb_rd;
            mem_data[tail] <= wb_data;
        end
`ifdef WB_COALESCE_EN
        if (coal) begin
            mem_data[tail_m1] <= wb_data;
        end
`endif
    end

    // Head entry goes to the register file; zero when nothing is queued.
    always_comb begin
        rf_rd      = '0;
        rf_rd_data = '0;
        if (!empty_q) begin
            rf_rd      = {27'd0, mem_rd[head]};
            rf_rd_data = mem_data[head];
        end
    end

    // Forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx         = '0;
        fwd_rs1_hit = 1'b0;
        fwd_rs1     = '0;
        fwd_rs2_hit = 1'b0;
        fwd_rs2     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (ent_vld[idx] && rs1_addr != 5'd0 && mem_rd[idx] == rs1_addr) begin
                fwd_rs1_hit = 1'b1;
                fwd_rs1     = mem_data[idx];
            end
            if (ent_vld[idx] && rs2_addr != 5'd0 && mem_rd[idx] == rs2_addr) begin
                fwd_rs2_hit = 1'b1;
                fwd_rs2     = mem_data[idx];
            end
        end
    end

    assign count = count_q;
    assign empty = empty_q;

endmodule
